// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and serializer state encoding.
package mmio_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_IRQCTL  = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // The STATUS count field is only 4 bits wide; deeper FIFOs report 15.
    function automatic logic [3:0] sat_count4(input int unsigned c);
        return (c > 15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO, combinational head data, one-cycle push/pop.
// A push while full is dropped (drop_o) unless a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     drop_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pop_ok, push_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok    = pop_i && !empty_o;
    assign push_ok   = push_i && (!full_o || pop_ok);
    assign drop_o    = push_i && !push_ok;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter; zero-latency reads, full-FIFO stores drop and set overflow.
// Define UART_TX_IRQ_EN to add IRQCTL at offset 0xC and the registered irq output.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic        we,
    input  logic [2:0]  mode,
    output logic [31:0] rd,
    output logic        tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            wr_en, wr_txdata, wr_status, wr_div;
    logic            fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [7:0]      fifo_dat;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     status;
    logic            busy;

    tx_state_e       state_q;
    logic            tx_q;
    logic [7:0]      shift_q;
    logic [15:0]     baud_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [15:0]     div_q, div_d;
    logic            ovf_q, ovf_d;

    logic            unused_bits;
    assign unused_bits = ^{mode, a[31:4], a[1:0], wd[31:16]};

    assign wr_en     = sel && we;
    assign wr_txdata = wr_en && (a[3:2] == REG_TXDATA);
    assign wr_status = wr_en && (a[3:2] == REG_STATUS);
    assign wr_div    = wr_en && (a[3:2] == REG_BAUDDIV);

    assign busy = (state_q != S_IDLE);
    assign tx   = tx_q;

    // A new byte is taken either from IDLE or at the last clock of STOP,
    // the latter giving gap-free back-to-back frames.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == S_IDLE) || (state_q == S_STOP && baud_cnt_q == '0));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (wr_txdata),
        .push_dat_i (wd[7:0]),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .drop_o     (fifo_drop),
        .count_o    (fifo_count)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (wr_status && wd[ST_OVF]) ovf_d = 1'b0;
        if (fifo_drop)               ovf_d = 1'b1;
        div_d = wr_div ? wd[15:0] : div_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            div_q <= DEFAULT_DIV;
        end else begin
            ovf_q <= ovf_d;
            div_q <= div_d;
        end
    end

    // Each bit reloads the baud counter from div_q, so a divisor change
    // only affects bits that start after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (fifo_pop) begin
                        shift_q    <= fifo_dat;
                        baud_cnt_q <= div_q;
                        bit_cnt_q  <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt_q == '0) begin
                        baud_cnt_q <= div_q;
                        tx_q       <= shift_q[0];
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt_q == '0) begin
                        baud_cnt_q <= div_q;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt_q == '0) begin
                        if (fifo_pop) begin
                            shift_q    <= fifo_dat;
                            baud_cnt_q <= div_q;
                            bit_cnt_q  <= '0;
                            tx_q       <= 1'b0;
                            state_q    <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q - 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    logic ien_q, irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ien_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_en && (a[3:2] == REG_IRQCTL)) ien_q <= wd[0];
            irq_q <= ien_q && fifo_empty && !busy;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        status                    = '0;
        status[ST_BUSY]           = busy;
        status[ST_FULL]           = fifo_full;
        status[ST_EMPTY]          = fifo_empty;
        status[ST_OVF]            = ovf_q;
        status[ST_CNT_LSB +: 4]   = sat_count4(int'(fifo_count));
    end

    always_comb begin
        rd = '0;
        if (sel) begin
            case (a[3:2])
                REG_STATUS:  rd = status;
                REG_BAUDDIV: rd = {16'b0, div_q};
`ifdef UART_TX_IRQ_EN
                REG_IRQCTL:  rd = {31'b0, ien_q};
`endif
                default:     rd = '0;
            endcase
        end
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter; the responder on the CPU data-memory bus, beside dmem.
- Uses the same a/rd/wd/we/mode signalling that dmem presents, qualified by an address-decode select.
- CPU stores bytes into a small TX FIFO; a serializer shifts them out on tx as 8N1 frames at a programmable baud divisor.
- Status and divisor are readable, so firmware can poll.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, minimum 2.
- DEFAULT_DIV, 16'd3, reset value of BAUDDIV; clocks per bit = BAUDDIV+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sel  in  1  address decode hit for this block's 16-byte window.
- a  in  32  byte address; only a[3:2] decoded.
- wd  in  32  store data.
- we  in  1  store enable; qualified by sel.
- mode  in  3  dmem access mode (funct3); accepted and ignored, so every store uses the low bits of wd.
- rd  out  32  load data; combinational from a[3:2]; 0 when sel=0.
- tx  out  1  serial line; idles high.

Behaviour:
- Register map (offset from a[3:2]):
  - 0x0 TXDATA: a write pushes wd[7:0]; reads return 0.
  - 0x4 STATUS: bit0 busy (serializer not IDLE); bit1 full; bit2 empty; bit3 overflow (sticky); bits[7:4] FIFO count (saturating at 15); rest 0. Writing 1 to wd[3] clears overflow; other bits read-only.
  - 0x8 BAUDDIV: bits[15:0] read/write; upper bits read 0.
  - 0xC: reserved; reads 0, writes ignored.
- Writes take effect on the rising clk edge where sel&&we. Reads have zero latency, matching dmem.
- FIFO:
  - Push on a TXDATA write.
  - Pop when the serializer leaves IDLE.
  - Push while full is dropped and sets overflow, unless a pop happens in the same cycle; then the push is accepted and count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Serializer FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: tx=1. If the FIFO is non-empty, pop into an 8-bit shift register, load the bit counter, and go to START on the next edge.
  - START: tx=0 for BAUDDIV+1 clocks.
  - DATA: tx=shift[0] for 8 bits, LSB first. Each bit lasts BAUDDIV+1 clocks, then shift right.
  - STOP: tx=1 for BAUDDIV+1 clocks. Then go to IDLE, or go directly to START if the FIFO is non-empty, giving back-to-back frames with no idle gap.
- Frame length is exactly 10*(BAUDDIV+1) clocks.
- tx is registered, so it changes only on clk edges.
- A BAUDDIV write mid-frame applies from the next bit boundary (baud counter reload). The current bit keeps its length.
- BAUDDIV=0 is legal: 1 clock per bit.
- Async reset, including mid-frame:
  - tx=1; FSM=IDLE; FIFO empty with pointers 0; overflow=0; BAUDDIV=DEFAULT_DIV; baud and bit counters 0.
  - rd is 0 while sel=0.
  - The frame in progress is aborted with no completion.

Optional Feature:
- Macro UART_TX_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - Offset 0xC becomes IRQCTL, bit0 ien (read/write, reset 0).
  - irq = ien & empty & ~busy, registered, reset 0.
- Undefined: no irq port; 0xC reserved as above.

Decomposition:
- Shared package holds:
  - register offset constants (TXDATA, STATUS, BAUDDIV, IRQCTL);
  - STATUS bit index constants;
  - FSM state encoding (2-bit IDLE/START/DATA/STOP).
- One natural sub-module: uart_tx_fifo, a parameterized synchronous FIFO with push/pop/full/empty/count and simultaneous push-pop on full.

Test Plan:
- Reset, then read 0x4 and 0x8 -> STATUS=0x004 (empty only), BAUDDIV=3, tx=1.
- Write 0xA5 to 0x0 -> tx low for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop high. Frame is 40 clocks; busy=1 throughout.
- Write 6 bytes back-to-back with FIFO_DEPTH=4:
  - First byte pops immediately, so 5 enter the FIFO.
  - Sixth write is dropped: overflow=1, count=4.
  - Frames are contiguous with no idle between stop and start.
  - Writing 0x8 to 0x4 clears overflow.
- Set BAUDDIV=0, send 0x00 -> 10-clock frame with tx low for 9 clocks. Change BAUDDIV to 7 mid-DATA -> the next bit lasts 8 clocks.
- Assert reset mid-DATA -> tx=1 immediately (asynchronous), FIFO empty, no residual frame after release.
- (UART_TX_IRQ_EN) Write 1 to 0xC, send one byte -> irq=0 during the frame; irq=1 one clock after return to IDLE with the FIFO empty.
